// File: rtl/aes_rr_scheduler.sv
// Round-robin front end sharing one fixed-latency, non-stalling AES-128 pipeline between
// NREQ requesters; a tag pipe running alongside the core routes each ciphertext home.
module aes_rr_scheduler #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int LAT  = 10,
    localparam int CW  = $clog2(LAT + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*128-1:0] req_p,
    input  logic [NREQ*128-1:0] req_k,
    output logic [NREQ-1:0]     req_ready,
    output logic [127:0]        core_p,
    output logic [127:0]        core_k,
    input  logic [127:0]        core_c,
    input  logic                core_valid,
    output logic                resp_valid,
    output logic [IDW-1:0]      resp_id,
    output logic [127:0]        resp_c,
    output logic [CW-1:0]       inflight,
    output logic                err
);

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_next;
    logic [IDW-1:0] grant_id;
    logic [IDW-1:0] scan_idx;
    logic           any_req;
    logic           handshake;
    logic [NREQ-1:0] grant;

    logic           tag_v  [LAT];
    logic [IDW-1:0] tag_id [LAT];

    // Scan downward so the closest requester at or after ptr is the last one to win.
    always_comb begin
        grant_id = '0;
        scan_idx = '0;
        any_req  = 1'b0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            scan_idx = IDW'((int'(ptr) + off) % NREQ);
            if (req_valid[scan_idx]) begin
                grant_id = scan_idx;
                any_req  = 1'b1;
            end
        end
    end

    always_comb begin
        grant = '0;
        if (any_req && !rst) begin
            grant[grant_id] = 1'b1;
        end
    end

    assign req_ready = grant;
    assign handshake = any_req & ~rst;
    assign ptr_next  = (int'(grant_id) == NREQ - 1) ? '0 : grant_id + 1'b1;
    assign resp_c    = core_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            core_p <= '0;
            core_k <= '0;
            ptr    <= '0;
        end else if (handshake) begin
            core_p <= req_p[128*grant_id +: 128];
            core_k <= req_k[128*grant_id +: 128];
            ptr    <= ptr_next;
        end
    end

    // The output register after the last slot lines the tag up with core_c LAT edges on.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                tag_v[i]  <= 1'b0;
                tag_id[i] <= '0;
            end
            resp_valid <= 1'b0;
            resp_id    <= '0;
        end else begin
            tag_v[0]  <= handshake;
            tag_id[0] <= handshake ? grant_id : '0;
            for (int i = 1; i < LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
            resp_valid <= tag_v[LAT-1];
            resp_id    <= tag_id[LAT-1];
        end
    end

    // A block leaves the count as its tag moves into the response register, capping it at LAT.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
        end else if (handshake && !tag_v[LAT-1] && inflight != CW'(LAT)) begin
            inflight <= inflight + 1'b1;
        end else if (!handshake && tag_v[LAT-1] && inflight != '0) begin
            inflight <= inflight - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (resp_valid && !core_valid) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_aes_rr_scheduler.sv
// Bench for aes_rr_scheduler: a stand-in fixed-latency core plus a queue-based model of
// issue order, arbitration distance and response timing.
module tb_aes_rr_scheduler;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int LAT  = 10;
    localparam int CW   = $clog2(LAT + 1);

    localparam logic [127:0] KAT_P = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KAT_K = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KAT_C = 128'h3925841d02dc09fbdc118597196a0b32;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*128-1:0] req_p;
    logic [NREQ*128-1:0] req_k;
    logic [NREQ-1:0]     req_ready;
    logic [127:0]        core_p;
    logic [127:0]        core_k;
    logic [127:0]        core_c;
    logic                core_valid;
    logic                resp_valid;
    logic [IDW-1:0]      resp_id;
    logic [127:0]        resp_c;
    logic [CW-1:0]       inflight;
    logic                err;

    aes_rr_scheduler #(.NREQ(NREQ), .IDW(IDW), .LAT(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_p      (req_p),
        .req_k      (req_k),
        .req_ready  (req_ready),
        .core_p     (core_p),
        .core_k     (core_k),
        .core_c     (core_c),
        .core_valid (core_valid),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_c     (resp_c),
        .inflight   (inflight),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Known-answer vector maps to the real AES result; anything else to a cheap keyed mix.
    function automatic logic [127:0] core_f(input logic [127:0] p, input logic [127:0] k);
        if (p == KAT_P && k == KAT_K) return KAT_C;
        return {p[63:0] ^ k[127:64], p[127:64] + k[63:0]} ^ 128'h5a5a_0f0f_c3c3_9696_1234_5678_9abc_def0;
    endfunction

    logic [127:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= core_f(core_p, core_k);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign core_c = pipe[LAT-1];

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct {
        int           id;
        logic [127:0] c;
        int           due;
    } exp_t;

    exp_t            q[$];
    int              m_ptr;
    logic            exp_rv;
    int              exp_id;
    logic [127:0]    exp_c;
    logic            err_exp;
    logic [NREQ-1:0] exp_grant;
    logic            cv;
    int              checks = 0;
    int              errors = 0;

    assign core_valid = cv;

    // Winner is the requesting index at the smallest circular distance from the pointer.
    function automatic int model_pick(input logic [NREQ-1:0] v, input int ptr);
        int best = -1;
        int bestd = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            if (v[i] && ((i - ptr + NREQ) % NREQ) < bestd) begin
                bestd = (i - ptr + NREQ) % NREQ;
                best  = i;
            end
        end
        return best;
    endfunction

    task automatic model_expect();
        exp_rv = 1'b0;
        exp_id = 0;
        exp_c  = '0;
        if (q.size() > 0 && q[0].due == edge_n) begin
            exp_rv = 1'b1;
            exp_id = q[0].id;
            exp_c  = q[0].c;
            void'(q.pop_front());
        end
        if (exp_rv && !cv) err_exp = 1'b1;
    endtask

    task automatic drive_and_issue(input logic [NREQ-1:0] mask, input bit rand_data);
        int g;
        exp_t e;
        if (rand_data) begin
            for (int i = 0; i < NREQ; i++) begin
                req_p[128*i +: 128] = {$urandom, $urandom, $urandom, $urandom};
                req_k[128*i +: 128] = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        req_valid = mask;
        #1;
        g = model_pick(mask, m_ptr);
        exp_grant = '0;
        if (g >= 0) begin
            exp_grant[g] = 1'b1;
            e.id  = g;
            e.c   = core_f(req_p[128*g +: 128], req_k[128*g +: 128]);
            e.due = edge_n + 1 + LAT;
            q.push_back(e);
            m_ptr = (g + 1) % NREQ;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;
        q.delete();
        m_ptr   = 0;
        err_exp = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '1;
        q.delete();
        m_ptr   = 0;
        err_exp = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (req_ready !== '0) begin
                errors++;
                $display("[TB] FAIL reset_ready_in_rst got=%b want=0000", req_ready);
            end
            @(negedge clk);
        end
        rst       = 1'b0;
        req_valid = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== '0 || resp_valid !== 1'b0 || inflight !== '0 || core_p !== '0 || err !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_idle cyc=%0d got ready=%b rv=%b infl=%0d core_p=%h err=%b want all zero",
                         i, req_ready, resp_valid, inflight, core_p, err);
            end
        end
    endtask

    task automatic test_single_kat();
        bit seen = 0;
        req_p[127:0] = KAT_P;
        req_k[127:0] = KAT_K;
        for (int i = 0; i < LAT + 5; i++) begin
            @(negedge clk);
            model_expect();
            checks++;
            if (resp_valid !== exp_rv) begin
                errors++;
                $display("[TB] FAIL kat_rv cyc=%0d got=%b want=%b", i, resp_valid, exp_rv);
            end
            if (exp_rv) begin
                seen = 1;
                checks++;
                if (resp_id !== IDW'(0) || resp_c !== KAT_C) begin
                    errors++;
                    $display("[TB] FAIL kat_resp got id=%0d c=%h want id=0 c=%h", resp_id, resp_c, KAT_C);
                end
            end
            checks++;
            if (inflight !== CW'(q.size())) begin
                errors++;
                $display("[TB] FAIL kat_inflight cyc=%0d got=%0d want=%0d", i, inflight, q.size());
            end
            drive_and_issue((i == 0) ? 4'b0001 : 4'b0000, 0);
            checks++;
            if (req_ready !== exp_grant) begin
                errors++;
                $display("[TB] FAIL kat_grant cyc=%0d got=%b want=%b", i, req_ready, exp_grant);
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL kat_seen got=0 want=1");
        end
    endtask

    task automatic test_all_continuous();
        int max_infl = 0;
        int nresp = 0;
        for (int i = 0; i < 100 + LAT + 3; i++) begin
            @(negedge clk);
            checks++;
            if (err !== err_exp) begin
                errors++;
                $display("[TB] FAIL cont_err got=%b want=%b", err, err_exp);
            end
            model_expect();
            checks++;
            if (resp_valid !== exp_rv) begin
                errors++;
                $display("[TB] FAIL cont_rv cyc=%0d got=%b want=%b", i, resp_valid, exp_rv);
            end
            if (exp_rv) begin
                nresp++;
                checks++;
                if (resp_id !== IDW'(exp_id) || resp_c !== exp_c) begin
                    errors++;
                    $display("[TB] FAIL cont_resp cyc=%0d got id=%0d c=%h want id=%0d c=%h",
                             i, resp_id, resp_c, exp_id, exp_c);
                end
            end
            checks++;
            if (inflight !== CW'(q.size())) begin
                errors++;
                $display("[TB] FAIL cont_inflight cyc=%0d got=%0d want=%0d", i, inflight, q.size());
            end
            if (int'(inflight) > max_infl) max_infl = int'(inflight);
            drive_and_issue((i < 100) ? 4'b1111 : 4'b0000, 1);
            checks++;
            if (req_ready !== exp_grant) begin
                errors++;
                $display("[TB] FAIL cont_grant cyc=%0d got=%b want=%b", i, req_ready, exp_grant);
            end
        end
        checks++;
        if (max_infl != LAT || nresp != 100) begin
            errors++;
            $display("[TB] FAIL cont_totals got max_infl=%0d nresp=%0d want %0d and 100", max_infl, nresp, LAT);
        end
    endtask

    task automatic test_skip_idle();
        logic [NREQ-1:0] want [3];
        want[0] = 4'b1000;
        want[1] = 4'b0010;
        want[2] = 4'b1000;
        for (int i = 0; i < 4 + LAT + 2; i++) begin
            @(negedge clk);
            model_expect();
            checks++;
            if (resp_valid !== exp_rv || (exp_rv && (resp_id !== IDW'(exp_id) || resp_c !== exp_c))) begin
                errors++;
                $display("[TB] FAIL skip_resp cyc=%0d got rv=%b id=%0d want rv=%b id=%0d",
                         i, resp_valid, resp_id, exp_rv, exp_id);
            end
            drive_and_issue((i == 0) ? 4'b0010 : (i < 4) ? 4'b1010 : 4'b0000, 1);
            checks++;
            if (req_ready !== exp_grant) begin
                errors++;
                $display("[TB] FAIL skip_grant cyc=%0d got=%b want=%b", i, req_ready, exp_grant);
            end
            if (i >= 1 && i < 4) begin
                checks++;
                if (req_ready !== want[i-1]) begin
                    errors++;
                    $display("[TB] FAIL skip_table step=%0d got=%b want=%b", i - 1, req_ready, want[i-1]);
                end
            end
        end
    endtask

    task automatic test_random_traffic();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            model_expect();
            checks++;
            if (resp_valid !== exp_rv || (exp_rv && (resp_id !== IDW'(exp_id) || resp_c !== exp_c))) begin
                errors++;
                $display("[TB] FAIL rand_resp cyc=%0d got rv=%b id=%0d c=%h want rv=%b id=%0d c=%h",
                         i, resp_valid, resp_id, resp_c, exp_rv, exp_id, exp_c);
            end
            checks++;
            if (inflight !== CW'(q.size())) begin
                errors++;
                $display("[TB] FAIL rand_inflight cyc=%0d got=%0d want=%0d", i, inflight, q.size());
            end
            drive_and_issue((i < 300 - LAT - 3) ? NREQ'($urandom_range(0, 15)) : 4'b0000, 1);
            checks++;
            if (req_ready !== exp_grant) begin
                errors++;
                $display("[TB] FAIL rand_grant cyc=%0d got=%b want=%b", i, req_ready, exp_grant);
            end
        end
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < LAT + 3; i++) begin
            @(negedge clk);
            model_expect();
            drive_and_issue(4'b1111, 1);
        end
        @(negedge clk);
        checks++;
        if (inflight !== CW'(LAT)) begin
            errors++;
            $display("[TB] FAIL midrst_full got=%0d want=%0d", inflight, LAT);
        end
        do_reset();
        for (int i = 0; i < LAT + 5; i++) begin
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b0 || inflight !== '0 || err !== 1'b0) begin
                errors++;
                $display("[TB] FAIL midrst_drop cyc=%0d got rv=%b infl=%0d err=%b want 0 0 0",
                         i, resp_valid, inflight, err);
            end
        end
    endtask

    task automatic test_err_sticky();
        cv = 1'b0;
        for (int i = 0; i < LAT + 8; i++) begin
            @(negedge clk);
            checks++;
            if (err !== err_exp) begin
                errors++;
                $display("[TB] FAIL err_model cyc=%0d got=%b want=%b", i, err, err_exp);
            end
            model_expect();
            checks++;
            if (resp_valid !== exp_rv || (exp_rv && resp_id !== IDW'(exp_id))) begin
                errors++;
                $display("[TB] FAIL err_resp cyc=%0d got rv=%b id=%0d want rv=%b id=%0d",
                         i, resp_valid, resp_id, exp_rv, exp_id);
            end
            drive_and_issue((i == 0) ? 4'b0100 : 4'b0000, 1);
        end
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL err_set got=%b want=1", err);
        end
        do_reset();
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL err_clear got=%b want=0", err);
        end
        cv = 1'b1;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_p     = '0;
        req_k     = '0;
        cv        = 1'b1;
        m_ptr     = 0;
        err_exp   = 1'b0;
        exp_grant = '0;
        $display("[TB] starting aes_rr_scheduler bench");
        test_reset();
        test_single_kat();
        test_all_continuous();
        test_skip_idle();
        test_random_traffic();
        test_reset_midflight();
        test_err_sticky();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
